// File: rtl/mantenimiento_scheduler.sv
// Maintenance request initiator: periodic one-cycle request pulse, acknowledge
// timeout with bounded retries, sticky fault, and saturating request/completion counters.
module mantenimiento_scheduler #(
    parameter int PERIOD      = 1000,
    parameter int ACK_TIMEOUT = 200,
    parameter int MAX_RETRIES = 3,
    parameter int TW          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       force_req,
    input  logic       svc_done,
    input  logic       svc_fault,
    input  logic       fault_clr,
    output logic       req_pulse,
    output logic [2:0] state,
    output logic [7:0] req_count,
    output logic [7:0] done_count,
    output logic [7:0] retry_count,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_REQUEST   = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam logic [TW-1:0] PERIOD_LOAD = TW'(PERIOD - 1);
    localparam logic [TW-1:0] ACK_LOAD    = TW'(ACK_TIMEOUT - 1);
    localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRIES);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    req_cnt_q, req_cnt_d;
    logic [7:0]    done_cnt_q, done_cnt_d;
    logic [7:0]    retry_cnt_q, retry_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            req_cnt_q   <= '0;
            done_cnt_q  <= '0;
            retry_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            req_cnt_q   <= req_cnt_d;
            done_cnt_q  <= done_cnt_d;
            retry_cnt_q <= retry_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        req_cnt_d   = req_cnt_q;
        done_cnt_d  = done_cnt_q;
        retry_cnt_d = retry_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_COUNTDOWN;
                    timer_d = PERIOD_LOAD;
                end
            end

            ST_COUNTDOWN: begin
                // Disabling takes precedence over a forced request.
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (force_req || (timer_q == '0)) begin
                    state_d = ST_REQUEST;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_REQUEST: begin
                if (req_cnt_q != 8'hFF) begin
                    req_cnt_d = req_cnt_q + 8'd1;
                end
                timer_d = ACK_LOAD;
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (svc_fault) begin
                    state_d = ST_FAULT;
                end else if (svc_done) begin
                    state_d     = ST_COUNTDOWN;
                    timer_d     = PERIOD_LOAD;
                    retry_cnt_d = '0;
                    if (done_cnt_q != 8'hFF) begin
                        done_cnt_d = done_cnt_q + 8'd1;
                    end
                end else if (timer_q == '0) begin
                    if (retry_cnt_q == RETRY_LIMIT) begin
                        state_d = ST_FAULT;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 8'd1;
                        state_d     = ST_REQUEST;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            ST_FAULT: begin
                if (fault_clr) begin
                    state_d     = ST_IDLE;
                    retry_cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_pulse   = (state_q == ST_REQUEST);
    assign fault       = (state_q == ST_FAULT);
    assign state       = state_q;
    assign req_count   = req_cnt_q;
    assign done_count  = done_cnt_q;
    assign retry_count = retry_cnt_q;

endmodule

// File: tb/tb_mantenimiento_scheduler.sv
// Directed bench for mantenimiento_scheduler with PERIOD=10, ACK_TIMEOUT=5, MAX_RETRIES=2.
module tb_mantenimiento_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       force_req;
    logic       svc_done;
    logic       svc_fault;
    logic       fault_clr;
    logic       req_pulse;
    logic [2:0] state;
    logic [7:0] req_count;
    logic [7:0] done_count;
    logic [7:0] retry_count;
    logic       fault;

    int checks = 0;
    int errors = 0;

    mantenimiento_scheduler #(
        .PERIOD      (10),
        .ACK_TIMEOUT (5),
        .MAX_RETRIES (2),
        .TW          (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .force_req   (force_req),
        .svc_done    (svc_done),
        .svc_fault   (svc_fault),
        .fault_clr   (fault_clr),
        .req_pulse   (req_pulse),
        .state       (state),
        .req_count   (req_count),
        .done_count  (done_count),
        .retry_count (retry_count),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input string tag, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!req_pulse && n < 40);
        if (!req_pulse) check_eq({tag, "_seen"}, 32'(req_pulse), 32'd1);
    endtask

    task automatic do_request();
        int k;
        k = 0;
        while (state != 3'd1 && k < 20) begin
            step(1);
            k++;
        end
        if (state != 3'd1) check_eq("req_loop_wait", 32'(state), 32'd1);
        force_req = 1'b1;
        step(1);
        force_req = 1'b0;
        step(1);
        svc_done = 1'b1;
        step(1);
        svc_done = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; enable = 1'b0; force_req = 1'b0;
        svc_done = 1'b0; svc_fault = 1'b0; fault_clr = 1'b0;
        step(2);
        reset = 1'b0;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_pulse", 32'(req_pulse), 32'd0);
        check_eq("rst_reqcnt", 32'(req_count), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);

        // First periodic request
        enable = 1'b1;
        step(1);
        check_eq("en_state", 32'(state), 32'd1);
        wait_pulse("p1", n);
        check_eq("p1_delay", 32'(n), 32'd10);
        check_eq("p1_state", 32'(state), 32'd2);
        check_eq("p1_cnt_pre", 32'(req_count), 32'd0);
        step(1);
        check_eq("p1_width", 32'(req_pulse), 32'd0);
        check_eq("p1_wait_state", 32'(state), 32'd3);
        check_eq("p1_reqcnt", 32'(req_count), 32'd1);

        // Completion two cycles into WAIT_ACK
        step(1);
        svc_done = 1'b1;
        step(1);
        svc_done = 1'b0;
        check_eq("done_state", 32'(state), 32'd1);
        check_eq("done_cnt", 32'(done_count), 32'd1);
        check_eq("done_retry", 32'(retry_count), 32'd0);
        wait_pulse("p2", n);
        check_eq("p2_delay", 32'(n), 32'd10);

        // Asynchronous reset mid-run, checked between clock edges
        #3 reset = 1'b1;
        #1;
        check_eq("arst_state", 32'(state), 32'd0);
        check_eq("arst_pulse", 32'(req_pulse), 32'd0);
        check_eq("arst_reqcnt", 32'(req_count), 32'd0);
        check_eq("arst_donecnt", 32'(done_count), 32'd0);
        enable = 1'b0;
        step(1);
        reset = 1'b0;

        // No acknowledge: two retries then fault
        enable = 1'b1;
        step(1);
        check_eq("t4_state", 32'(state), 32'd1);
        wait_pulse("t4_p1", n);
        check_eq("t4_p1_delay", 32'(n), 32'd10);
        wait_pulse("t4_p2", n);
        check_eq("t4_retry1_delay", 32'(n), 32'd6);
        wait_pulse("t4_p3", n);
        check_eq("t4_retry2_delay", 32'(n), 32'd6);
        step(5);
        check_eq("t4_prefault_state", 32'(state), 32'd3);
        step(1);
        check_eq("t4_fault_state", 32'(state), 32'd4);
        check_eq("t4_fault_flag", 32'(fault), 32'd1);
        check_eq("t4_reqcnt", 32'(req_count), 32'd3);
        check_eq("t4_retry", 32'(retry_count), 32'd2);
        step(2);
        check_eq("t4_sticky", 32'(state), 32'd4);
        check_eq("t4_sticky_pulse", 32'(req_pulse), 32'd0);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check_eq("t4_clr_state", 32'(state), 32'd0);
        check_eq("t4_clr_retry", 32'(retry_count), 32'd0);
        check_eq("t4_clr_reqcnt", 32'(req_count), 32'd3);
        check_eq("t4_clr_fault", 32'(fault), 32'd0);

        // Forced request, svc_done during REQUEST ignored, fault beats done
        step(1);
        check_eq("t5_cd_state", 32'(state), 32'd1);
        force_req = 1'b1;
        step(1);
        force_req = 1'b0;
        check_eq("t5_force_state", 32'(state), 32'd2);
        check_eq("t5_force_pulse", 32'(req_pulse), 32'd1);
        svc_done = 1'b1;
        step(1);
        svc_done = 1'b0;
        check_eq("t5_early_done_state", 32'(state), 32'd3);
        check_eq("t5_early_done_cnt", 32'(done_count), 32'd0);
        check_eq("t5_reqcnt", 32'(req_count), 32'd4);
        force_req = 1'b1;
        step(2);
        force_req = 1'b0;
        check_eq("t5_wait_force_pulse", 32'(req_pulse), 32'd0);
        check_eq("t5_wait_force_state", 32'(state), 32'd3);
        svc_fault = 1'b1;
        svc_done  = 1'b1;
        step(1);
        svc_fault = 1'b0;
        svc_done  = 1'b0;
        check_eq("t5_fault_state", 32'(state), 32'd4);
        check_eq("t5_fault_donecnt", 32'(done_count), 32'd0);
        fault_clr = 1'b1;
        step(1);
        fault_clr = 1'b0;
        check_eq("t5_clr_state", 32'(state), 32'd0);

        // Disable wins over force_req
        step(1);
        check_eq("t6_cd_state", 32'(state), 32'd1);
        enable    = 1'b0;
        force_req = 1'b1;
        step(1);
        force_req = 1'b0;
        check_eq("t6_dis_state", 32'(state), 32'd0);
        check_eq("t6_dis_pulse", 32'(req_pulse), 32'd0);
        step(1);
        check_eq("t6_idle_reqcnt", 32'(req_count), 32'd4);

        // Drive req_count to 8'hFE, then saturate
        enable = 1'b1;
        for (int i = 0; i < 250; i++) do_request();
        check_eq("sat_pre_reqcnt", 32'(req_count), 32'hFE);
        check_eq("sat_pre_donecnt", 32'(done_count), 32'd250);
        for (int i = 0; i < 3; i++) do_request();
        check_eq("sat_reqcnt", 32'(req_count), 32'hFF);
        check_eq("sat_donecnt", 32'(done_count), 32'd253);
        check_eq("sat_state", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
